// File: rtl/imem_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// boot_pkg
//   Shared types and sizing helpers for the instruction-memory boot loader.
//   - boot_state_t   : loader FSM states
//   - BYTES_PER_WORD : bytes packed into one flash word
//   - MAX_WORDS      : number of words that fit in the flash address space
// ---------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } boot_state_t;

    function automatic int BYTES_PER_WORD(input int width);
        return width / 8;
    endfunction

    function automatic int MAX_WORDS(input int width, input int addr_width);
        return (1 << addr_width) / (width / 8);
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//   Collects bytes little-endian into a WIDTH-bit word: byte k of a word lands
//   in word[8k+7:8k]. word_o always shows the word as it would look with the
//   current byte_i placed in its slot, so the completed word is available in
//   the same cycle the final byte is accepted (word_valid_o pulses then).
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : restart packing at byte 0 (start of a new load)
//   byte_en_i     : byte_i is accepted this cycle
//   byte_i        : incoming stream byte
//   word_o        : assembled word (valid when word_valid_o is high)
//   word_valid_o  : this cycle's byte completes a word
// ---------------------------------------------------------------------------
module byte_packer
    import boot_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             byte_en_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o
);

    localparam int BYTES = BYTES_PER_WORD(WIDTH);
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] partial_q;

    always_comb begin
        word_o = partial_q;
        for (int k = 0; k < BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                word_o[8*k +: 8] = byte_i;
            end
        end
        word_valid_o = byte_en_i && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (byte_en_i) begin
            // Explicit wrap so non-power-of-two word sizes also work.
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            partial_q <= '0;
        end else if (clear_i) begin
            cnt_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (byte_en_i) begin
                partial_q <= word_o;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Boot-time program loader. Receives a byte stream: 16-bit little-endian
//   word count N, then N*BYTES program bytes. Packs the bytes into words,
//   issues one single-cycle flash write per word and holds the core in reset
//   until the whole image is written. N larger than the flash capacity sends
//   the loader to ERR, where it stays (core in reset) until the next start.
//
// Handshake: a byte moves when rx_valid && rx_ready are both high at a rising
//   edge. rx_ready is a registered output that is high only in LEN_LO, LEN_HI
//   and DATA; rx_valid may drop at any time (the loader simply waits) and
//   rx_data must be stable while rx_valid is high.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   start       : 1-cycle pulse, begins a load from IDLE/RUN/ERR
//   rx_data     : stream byte
//   rx_valid    : rx_data valid
//   rx_ready    : loader accepts a byte this cycle
//   flash_en    : 1-cycle flash write strobe
//   flash_addr  : byte address of the word being written
//   flash_data  : word being written
//   cpu_rst     : core reset (high until image loaded)
//   busy        : load in progress (LEN_LO..WRITE)
//   done        : image loaded, core running
//   err         : length exceeded capacity; sticky until start/rst
//   dbg_state   : current FSM state
// ---------------------------------------------------------------------------
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  flash_en,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0]      flash_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output boot_state_t           dbg_state
);

    localparam int BYTES = BYTES_PER_WORD(WIDTH);
    localparam logic [31:0]           MAXW_U    = 32'(MAX_WORDS(WIDTH, ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BYTES);

    boot_state_t           state_q, state_d;
    logic                  rx_ready_q;
    logic                  flash_en_q;
    logic [ADDR_WIDTH-1:0] flash_addr_q;
    logic [WIDTH-1:0]      flash_data_q;
    logic                  cpu_rst_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [7:0]            len_lo_q;
    logic [15:0]           words_q;

    logic                  xfer;
    logic                  enter_load;
    logic [15:0]           len_n;
    logic [WIDTH-1:0]      packed_word;
    logic                  word_valid;

    assign xfer  = rx_valid && rx_ready_q;
    assign len_n = {rx_data, len_lo_q};

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (enter_load),
        .byte_en_i    (xfer && (state_q == DATA)),
        .byte_i       (rx_data),
        .word_o       (packed_word),
        .word_valid_o (word_valid)
    );

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        enter_load = 1'b0;
        case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d    = LEN_LO;
                    enter_load = 1'b1;
                end
            end
            LEN_LO: begin
                if (xfer) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) begin
                    if (len_n == 16'd0)                 state_d = RUN;
                    else if ({16'd0, len_n} > MAXW_U)   state_d = ERR;
                    else                                state_d = DATA;
                end
            end
            DATA: begin
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                state_d = (words_q == 16'd1) ? RUN : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they always agree with
    // the state the FSM is entering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_ready_q   <= 1'b0;
            flash_en_q   <= 1'b0;
            flash_addr_q <= BASE;
            flash_data_q <= '0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            len_lo_q     <= '0;
            words_q      <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
            flash_en_q <= (state_d == WRITE);
            busy_q     <= (state_d == LEN_LO) || (state_d == LEN_HI) ||
                          (state_d == DATA)   || (state_d == WRITE);
            done_q     <= (state_d == RUN);
            cpu_rst_q  <= (state_d != RUN);
            err_q      <= (state_d == ERR);

            if (state_q == LEN_LO && xfer) len_lo_q <= rx_data;

            if (state_q == LEN_HI && xfer)  words_q <= len_n;
            else if (state_q == WRITE)      words_q <= words_q - 16'd1;

            // Data is captured with the completing byte so it is stable for
            // the whole WRITE cycle; the address steps only after WRITE.
            if (word_valid) flash_data_q <= packed_word;

            if (enter_load)            flash_addr_q <= BASE;
            else if (state_q == WRITE) flash_addr_q <= flash_addr_q + ADDR_STEP;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign flash_en   = flash_en_q;
    assign flash_addr = flash_addr_q;
    assign flash_data = flash_data_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;
  import boot_pkg::*;

  localparam int WIDTH = 32;
  localparam int AW    = 11;
  localparam int BASE  = 0;
  localparam int BYTES = WIDTH / 8;
  localparam int MAXW  = (1 << AW) / BYTES;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready, flash_en, cpu_rst, busy, done, err;
  logic [AW-1:0] flash_addr;
  logic [WIDTH-1:0] flash_data;
  boot_state_t dbg_state;

  always #5 clk = ~clk;

  imem_boot_loader #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .flash_en(flash_en), .flash_addr(flash_addr),
    .flash_data(flash_data), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [7:0]       stim_q[$];
  logic [AW-1:0]    exp_addr_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [AW-1:0]    got_addr_q[$];
  logic [WIDTH-1:0] got_q[$];
  int               ready_in_write;
  int               exp_kind; // 0: empty image, 1: normal image, 2: overflow

  always @(negedge clk) begin
    if (!rst && flash_en) begin
      got_addr_q.push_back(flash_addr);
      got_q.push_back(flash_data);
      if (rx_ready) ready_in_write++;
    end
  end

  // Reference model: parse the stream as count + little-endian words.
  task automatic model_image();
    int n;
    exp_addr_q.delete();
    exp_q.delete();
    n = int'(stim_q[0]) + 256 * int'(stim_q[1]);
    if (n == 0) exp_kind = 0;
    else if (n > MAXW) exp_kind = 2;
    else begin
      exp_kind = 1;
      for (int w = 0; w < n; w++) begin
        logic [WIDTH-1:0] word;
        word = '0;
        for (int k = 0; k < BYTES; k++)
          word = word + (WIDTH'(stim_q[2 + w*BYTES + k]) << (8*k));
        exp_addr_q.push_back(AW'((BASE + w*BYTES) % (1 << AW)));
        exp_q.push_back(word);
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int min_gap, input int max_gap);
    int gap;
    bit ok;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, min_gap)) : 0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL byte_accept: byte %h not accepted within 100 cycles", b);
    end
  endtask

  // Full load of stim_q; optional start pulse after byte index mid_start.
  task automatic run_load(input string name, input int min_gap, input int max_gap,
                          input int mid_start);
    int nbytes;
    got_addr_q.delete();
    got_q.delete();
    ready_in_write = 0;
    model_image();
    pulse_start();
    checks++;
    if (cpu_rst !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || flash_addr !== AW'(BASE)) begin
      failures++;
      $display("FAIL %s start_state: cpu_rst=%b busy=%b done=%b err=%b addr=%h required 1 1 0 0 %h",
               name, cpu_rst, busy, done, err, flash_addr, AW'(BASE));
    end
    nbytes = (exp_kind == 1) ? stim_q.size() : 2;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(stim_q[i], min_gap, max_gap);
      if (i == mid_start) begin
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL %s mid_start: busy=%b cpu_rst=%b done=%b required 1 1 0", name, busy, cpu_rst, done);
        end
      end
    end
    checks++;
    case (exp_kind)
      1: begin
        if (flash_en !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL %s write_latency: flash_en=%b done=%b required 1 0", name, flash_en, done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL %s done_latency: done=%b cpu_rst=%b busy=%b required 1 0 0", name, done, cpu_rst, busy);
        end
      end
      0: begin
        if (done !== 1'b1 || cpu_rst !== 1'b0 || flash_en !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL %s empty_run: done=%b cpu_rst=%b flash_en=%b busy=%b required 1 0 0 0",
                   name, done, cpu_rst, flash_en, busy);
        end
      end
      default: begin
        if (err !== 1'b1 || cpu_rst !== 1'b1 || rx_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL %s overflow_state: err=%b cpu_rst=%b rx_ready=%b done=%b busy=%b required 1 1 0 0 0",
                   name, err, cpu_rst, rx_ready, done, busy);
        end
      end
    endcase
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s write[%0d]: addr=%h data=%h required addr=%h data=%h",
                 name, i, got_addr_q[i], got_q[i], exp_addr_q[i], exp_q[i]);
      end
    end
    checks++;
    if (ready_in_write != 0) begin
      failures++;
      $display("FAIL %s ready_in_write: %0d cycles with rx_ready during write, required 0", name, ready_in_write);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (cpu_rst !== 1'b1 || flash_en !== 1'b0 || rx_ready !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || busy !== 1'b0 || flash_addr !== AW'(BASE) || flash_data !== '0) begin
        failures++;
        $display("FAIL reset_values: cpu_rst=%b flash_en=%b rx_ready=%b done=%b err=%b busy=%b addr=%h data=%h",
                 cpu_rst, flash_en, rx_ready, done, err, busy, flash_addr, flash_data);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (cpu_rst !== 1'b1 || rx_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: cpu_rst=%b rx_ready=%b busy=%b done=%b required 1 0 0 0", cpu_rst, rx_ready, busy, done);
    end
  endtask

  // Words 12345 (0x00003039) and 678910 (0x000A5BFE).
  task automatic set_two_word();
    stim_q = '{8'h02, 8'h00, 8'h39, 8'h30, 8'h00, 8'h00, 8'hFE, 8'h5B, 8'h0A, 8'h00};
  endtask

  task automatic test_two_word();
    set_two_word();
    run_load("two_word", 0, 0, -1);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 32'd12345 || got_q[1] !== 32'd678910 ||
        got_addr_q[0] !== 11'd0 || got_addr_q[1] !== 11'd4) begin
      failures++;
      $display("FAIL two_word_literal: writes=%0d, required 12345@0 and 678910@4", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    set_two_word();
    run_load("gaps", 1, 5, -1);
    for (int it = 0; it < 4; it++) begin
      int n;
      n = int'($urandom_range(6, 1));
      stim_q = '{};
      stim_q.push_back(8'(n));
      stim_q.push_back(8'h00);
      for (int i = 0; i < n * BYTES; i++) stim_q.push_back(8'($urandom));
      run_load("random_image", 0, 3, -1);
    end
  endtask

  task automatic test_zero_len();
    stim_q = '{8'h00, 8'h00};
    run_load("zero_len", 0, 0, -1);
  endtask

  task automatic test_overflow();
    stim_q = '{8'h01, 8'h02};
    run_load("overflow", 0, 0, -1);
    // Excess bytes must stay unconsumed.
    rx_valid = 1'b1; rx_data = 8'hA5;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (rx_ready !== 1'b0 || err !== 1'b1 || flash_en !== 1'b0) begin
        failures++;
        $display("FAIL overflow_hold: rx_ready=%b err=%b flash_en=%b required 0 1 0", rx_ready, err, flash_en);
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    stim_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("after_overflow", 0, 0, -1);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared: err=%b required 0", err);
    end
    // Exactly at capacity: must load, not overflow.
    stim_q = '{8'(MAXW % 256), 8'(MAXW / 256)};
    for (int i = 0; i < MAXW * BYTES; i++) stim_q.push_back(8'($urandom));
    run_load("full_capacity", 0, 0, -1);
  endtask

  task automatic test_abort_restart();
    got_addr_q.delete();
    got_q.delete();
    stim_q = '{8'h02, 8'h00, 8'hAA, 8'hBB};
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stim_q[i], 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_rst !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 || flash_en !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || flash_addr !== AW'(BASE) || flash_data !== '0) begin
      failures++;
      $display("FAIL abort_values: cpu_rst=%b busy=%b rx_ready=%b flash_en=%b done=%b err=%b addr=%h data=%h",
               cpu_rst, busy, rx_ready, flash_en, done, err, flash_addr, flash_data);
    end
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_write: writes=%0d busy=%b required 0 0", got_q.size(), busy);
    end
    // Start pulse after 2 data bytes (index 3) must be ignored.
    stim_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load("start_in_data", 0, 2, 3);
    // Start from RUN reloads from BASE.
    stim_q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load("reload_from_run", 0, 1, -1);
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_backpressure();
    test_zero_len();
    test_overflow();
    test_abort_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
